// File: rtl/result_serializer_pkg.sv
// Shared definitions for the result serializer: opcodes, frame byte counts,
// FSM state encoding and small helpers used when a result is captured.
package result_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_e;

  localparam logic [1:0] OP_ENC = 2'b00;
  localparam logic [1:0] OP_DEC = 2'b01;
  localparam logic [1:0] OP_PWD = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  localparam int unsigned ENC_BYTES = 12;
  localparam int unsigned TXT_BYTES = 10;

  // Remaining-byte count loaded when the first payload byte is presented
  function automatic logic [3:0] firstCount(input logic isEnc);
    return isEnc ? 4'(ENC_BYTES - 1) : 4'(TXT_BYTES - 1);
  endfunction

  // Only the three defined opcodes produce a frame
  function automatic logic isLegal(input logic [1:0] op);
    return op != OP_ILL;
  endfunction

  // Ciphertext fills the whole register; 80-bit text is left-aligned
  function automatic logic [95:0] alignPayload(input logic [1:0]  op,
                                               input logic [95:0] enc,
                                               input logic [79:0] plain);
    return (op == OP_ENC) ? enc : {plain, 16'h0000};
  endfunction

endpackage

// File: rtl/result_serializer.sv
// Result serializer: accepts one Solver result at a time and streams it out
// as a header byte followed by the payload, MSB first, over a valid/ready
// byte interface. Illegal opcodes are dropped with a one-cycle error pulse.
module result_serializer
  import result_serializer_pkg::*;
#(
  parameter logic [7:0] HDR_BASE = 8'hA0
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  work_2,
  input  logic [95:0] enc_96,
  input  logic [79:0] plain_80,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        byte_last,
  output logic        err_pulse,
  output logic [7:0]  frame_cnt
);

  state_e      state_q,     state_d;
  logic [95:0] shift_q,     shift_d;
  logic [3:0]  cnt_q,       cnt_d;
  logic        isEnc_q,     isEnc_d;
  logic [7:0]  byteOut_q,   byteOut_d;
  logic        byteValid_q, byteValid_d;
  logic        byteLast_q,  byteLast_d;
  logic        errPulse_q,  errPulse_d;
  logic [7:0]  frameCnt_q,  frameCnt_d;
  logic        started_q;

  logic        inXfer;
  logic        byteXfer;
  logic        lastXfer;
  logic [7:0]  hdrByte;
  logic [95:0] loadShift;

  // Handshake decode; the input side reopens during the final byte transfer
  always_comb begin
    byteXfer  = byteValid_q && byte_ready;
    lastXfer  = (state_q == ST_PAYLOAD) && byteXfer && (cnt_q == 4'd0);
    in_ready  = started_q && ((state_q == ST_IDLE) || lastXfer);
    inXfer    = in_valid && in_ready;
    hdrByte   = {HDR_BASE[7:2], work_2};
    loadShift = alignPayload(work_2, enc_96, plain_80);
  end

  // Next-state logic: walk header then payload bytes, capture new results
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    isEnc_d     = isEnc_q;
    byteOut_d   = byteOut_q;
    byteValid_d = byteValid_q;
    byteLast_d  = byteLast_q;
    errPulse_d  = 1'b0;
    frameCnt_d  = frameCnt_q;

    case (state_q)
      ST_IDLE: begin
        byteValid_d = 1'b0;
        byteLast_d  = 1'b0;
      end

      ST_HEADER: begin
        if (byteXfer) begin
          state_d    = ST_PAYLOAD;
          cnt_d      = firstCount(isEnc_q);
          byteOut_d  = shift_q[95:88];
          shift_d    = {shift_q[87:0], 8'h00};
          byteLast_d = 1'b0;
        end
      end

      ST_PAYLOAD: begin
        if (byteXfer) begin
          if (cnt_q == 4'd0) begin
            state_d     = ST_IDLE;
            frameCnt_d  = frameCnt_q + 8'd1;
            byteOut_d   = 8'h00;
            byteValid_d = 1'b0;
            byteLast_d  = 1'b0;
          end else begin
            cnt_d      = cnt_q - 4'd1;
            byteOut_d  = shift_q[95:88];
            shift_d    = {shift_q[87:0], 8'h00};
            byteLast_d = (cnt_q == 4'd1);
          end
        end
      end

      default: begin
        state_d     = ST_IDLE;
        byteValid_d = 1'b0;
        byteLast_d  = 1'b0;
      end
    endcase

    if (inXfer) begin
      if (isLegal(work_2)) begin
        state_d     = ST_HEADER;
        shift_d     = loadShift;
        isEnc_d     = (work_2 == OP_ENC);
        byteOut_d   = hdrByte;
        byteValid_d = 1'b1;
        byteLast_d  = 1'b0;
      end else begin
        state_d    = ST_IDLE;
        errPulse_d = 1'b1;
      end
    end
  end

  // State and registered outputs; reset abandons any frame in progress
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      isEnc_q     <= 1'b0;
      byteOut_q   <= '0;
      byteValid_q <= 1'b0;
      byteLast_q  <= 1'b0;
      errPulse_q  <= 1'b0;
      frameCnt_q  <= '0;
      started_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      isEnc_q     <= isEnc_d;
      byteOut_q   <= byteOut_d;
      byteValid_q <= byteValid_d;
      byteLast_q  <= byteLast_d;
      errPulse_q  <= errPulse_d;
      frameCnt_q  <= frameCnt_d;
      started_q   <= 1'b1;
    end
  end

  assign byte_out   = byteOut_q;
  assign byte_valid = byteValid_q;
  assign byte_last  = byteLast_q;
  assign err_pulse  = errPulse_q;
  assign frame_cnt  = frameCnt_q;

endmodule

// File: doc/result_serializer.md
RESULT_SERIALIZER -- requirements
Module: result_serializer

Interface
REQ-001 The block SHALL have parameter HDR_BASE, default 8'hA0: the upper six bits of the frame header byte.
REQ-002 The block SHALL have port Clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port Rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1: a Solver result is present on the input ports.
REQ-005 The block SHALL have port in_ready, output, 1: the block can accept a result this cycle.
REQ-006 The block SHALL have port work_2, input, 2: operation code of the result (00 encrypt, 01 decrypt, 10 password, 11 illegal).
REQ-007 The block SHALL have port enc_96, input, 96: ciphertext, used when work_2=00.
REQ-008 The block SHALL have port plain_80, input, 80: decrypted text (work_2=01) or generated password (work_2=10).
REQ-009 The block SHALL have port byte_out, output, 8: the current byte of the outgoing stream.
REQ-010 The block SHALL have port byte_valid, output, 1: byte_out holds a valid byte.
REQ-011 The block SHALL have port byte_ready, input, 1: the sink accepts byte_out this cycle.
REQ-012 The block SHALL have port byte_last, output, 1: byte_out is the final byte of the frame.
REQ-013 The block SHALL have port err_pulse, output, 1: pulses for one cycle when an illegal code is dropped.
REQ-014 The block SHALL have port frame_cnt, output, 8: count of completed frames.

Function
REQ-015 An input transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; a byte transfer SHALL occur on a rising edge where byte_valid=1 and byte_ready=1.
REQ-016 The block SHALL implement the FSM states IDLE, HEADER and PAYLOAD.
REQ-017 In IDLE, in_ready SHALL be 1 and byte_valid SHALL be 0.
REQ-018 On a transfer with work_2 in 00..10, the block SHALL capture the payload and move to HEADER; the header byte SHALL be valid in the next cycle (1-cycle latency).
REQ-019 In HEADER, byte_out SHALL equal {HDR_BASE[7:2], work_2}; on its byte transfer the block SHALL move to PAYLOAD.
REQ-020 In PAYLOAD, the payload SHALL be sent MSB-first, 8 bits per byte: 12 bytes for code 00, 10 bytes for codes 01 and 10.
REQ-021 A 4-bit remaining-byte counter SHALL load 11 or 9 on entry to PAYLOAD and decrement on each byte transfer; byte_last SHALL be 1 only when the counter is 0.
REQ-022 While byte_valid=1 and byte_ready=0, byte_out and byte_last SHALL remain stable and byte_valid SHALL stay 1.
REQ-023 in_ready SHALL also be 1 during the cycle in which the last payload byte transfers, so frames can run back to back.
REQ-024 If that cycle also sees in_valid=1, the next state SHALL be HEADER; otherwise it SHALL be IDLE.
REQ-025 At every other time in HEADER and PAYLOAD, in_ready SHALL be 0.
REQ-026 On a transfer with work_2=11, the block SHALL drop the data, stay in or return to IDLE, and assert err_pulse for exactly one cycle; no bytes SHALL be emitted.
REQ-027 frame_cnt SHALL increment by 1 on each last-byte transfer and SHALL wrap from 255 to 0.
REQ-028 Bytes SHALL never be emitted for an unaccepted input, and no byte SHALL be duplicated or skipped under any byte_ready pattern.

Reset
REQ-029 While Rst_n=0, the block SHALL asynchronously enter IDLE and set byte_out=0, byte_valid=0, byte_last=0, err_pulse=0, frame_cnt=0, the counter to 0, and the payload register to 0.
REQ-030 in_ready SHALL be 0 while Rst_n=0 and SHALL be 1 from the first clock after release.
REQ-031 Reset mid-frame SHALL abandon the frame; no remaining bytes SHALL be emitted after release.

Structure
REQ-032 The opcode constants (ENC=2'b00, DEC=2'b01, PWD=2'b10), the byte counts 12 and 10, and the FSM state encoding SHALL reside in the shared solver package.
REQ-033 The block SHALL be a single module with no sub-modules; the payload SHALL be held in one 96-bit shift register, with 80-bit payloads left-aligned.

Verification
REQ-034 Send enc_96=96'h0102..0C with code 00 and byte_ready=1 -> the stream SHALL be A0,01..0C; byte_last SHALL be 1 on 0C only; frame_cnt SHALL be 1.
REQ-035 Send plain_80=80'hAABB..(10 bytes) with code 10 -> the stream SHALL be A2 followed by 10 bytes; in_ready SHALL be 0 from the header cycle to the last byte.
REQ-036 Hold byte_ready=0 for 5 cycles mid-payload -> byte_out SHALL stay constant and no byte SHALL be lost.
REQ-037 Apply in_valid continuously with two code-01 results -> the second header SHALL follow the first frame's last byte with no idle cycle.
REQ-038 Send code 11 -> err_pulse SHALL be high for 1 cycle, byte_valid SHALL stay 0, and frame_cnt SHALL be unchanged.
REQ-039 Pulse Rst_n low during byte 5 -> all outputs SHALL read 0 immediately and the next frame SHALL start with a header.
